// File: rtl/pushbutton_conditioner.sv
// Four-channel pushbutton conditioner: 2-flop synchronizer, debounce filter,
// press/release edge pulses and per-button auto-repeat.
module pushbutton_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] key_n,
    input  logic [3:0] repeat_en,
    output logic [3:0] pushbuttons_export,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [3:0] btn_repeat
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int RD_W = $clog2(REPEAT_DELAY);
    localparam int RP_W = $clog2(REPEAT_PERIOD);
    localparam int RC_W = (RD_W > RP_W) ? RD_W : RP_W;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } state_t;

    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      stable_q, stable_d;
    logic [3:0]      press_q, press_d;
    logic [3:0]      release_q, release_d;
    logic [3:0]      repeat_q, repeat_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [RC_W-1:0] rep_cnt_q [4];
    logic [RC_W-1:0] rep_cnt_d [4];
    state_t          state_q [4];
    state_t          state_d [4];

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        press_d   = 4'h0;
        release_d = 4'h0;
        repeat_d  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i]  = db_cnt_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            state_d[i]   = state_q[i];
        end

        for (int i = 0; i < 4; i++) begin
            // Counter tracks how long sync2 has disagreed with the debounced level.
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i]  = '0;
                stable_d[i]  = sync2_q[i];
                press_d[i]   = ~sync2_q[i];
                release_d[i] = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end

            unique case (state_q[i])
                RELEASED: begin
                    if (press_d[i]) begin
                        state_d[i]   = HOLD_DELAY;
                        rep_cnt_d[i] = '0;
                    end
                end
                HOLD_DELAY: begin
                    // Release wins over a coincident terminal count.
                    if (release_d[i]) begin
                        state_d[i]   = RELEASED;
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == DELAY_LAST) begin
                        if (repeat_en[i]) begin
                            repeat_d[i]  = 1'b1;
                            rep_cnt_d[i] = '0;
                            state_d[i]   = HOLD_REPEAT;
                        end
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + RC_W'(1);
                    end
                end
                HOLD_REPEAT: begin
                    if (release_d[i]) begin
                        state_d[i]   = RELEASED;
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == PERIOD_LAST) begin
                        if (repeat_en[i]) begin
                            repeat_d[i]  = 1'b1;
                            rep_cnt_d[i] = '0;
                        end
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + RC_W'(1);
                    end
                end
                default: begin
                    state_d[i]   = RELEASED;
                    rep_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            stable_q  <= 4'hF;
            press_q   <= 4'h0;
            release_q <= 4'h0;
            repeat_q  <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= '0;
                rep_cnt_q[i] <= '0;
                state_q[i]   <= RELEASED;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign pushbuttons_export = stable_q;
    assign btn_press          = press_q;
    assign btn_release        = release_q;
    assign btn_repeat         = repeat_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Scoreboard bench for pushbutton_conditioner: a window/timestamp reference model
// predicts every cycle's outputs, and a monitor compares them after each edge.
module tb_pushbutton_conditioner;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] repeat_en = 4'h0;
    logic [3:0] pushbuttons_export, btn_press, btn_release, btn_repeat;

    int total = 0;
    int bad = 0;

    logic [15:0] expq[$];

    bit [3:0] pipe[$];
    bit [3:0] win[$];
    bit [3:0] stable;
    bit       held[4];
    int       due[4];
    int       cyc = 0;

    pushbutton_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_clk           (clk),
        .reset_reset       (reset_reset),
        .key_n             (key_n),
        .repeat_en         (repeat_en),
        .pushbuttons_export(pushbuttons_export),
        .btn_press         (btn_press),
        .btn_release       (btn_release),
        .btn_repeat        (btn_repeat)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the last D synchronized samples all
    // disagree with it; repeats fire on timestamps relative to the press.
    task automatic model(input logic [3:0] k, input logic [3:0] r, input logic rs);
        bit [3:0] s2, prs, rel, rep;
        bit       all_diff;
        cyc++;
        prs = 0;
        rel = 0;
        rep = 0;
        if (rs) begin
            pipe.delete();
            pipe.push_back(4'hF);
            pipe.push_back(4'hF);
            win.delete();
            stable = 4'hF;
            for (int b = 0; b < 4; b++) held[b] = 0;
        end else begin
            s2 = pipe.pop_front();
            pipe.push_back(k);
            win.push_back(s2);
            if (win.size() > D) void'(win.pop_front());
            for (int b = 0; b < 4; b++) begin
                if (win.size() == D) begin
                    all_diff = 1;
                    foreach (win[j]) if (win[j][b] == stable[b]) all_diff = 0;
                    if (all_diff) begin
                        stable[b] = s2[b];
                        if (s2[b]) rel[b] = 1;
                        else prs[b] = 1;
                    end
                end
                if (prs[b]) begin
                    held[b] = 1;
                    due[b]  = cyc + RD;
                end else if (rel[b]) begin
                    held[b] = 0;
                end else if (held[b] && r[b] && cyc >= due[b]) begin
                    rep[b] = 1;
                    due[b] = cyc + RP;
                end
            end
        end
        expq.push_back({stable, prs, rel, rep});
    endtask

    task automatic step(input logic [3:0] k, input logic [3:0] r, input logic rs);
        @(negedge clk);
        key_n       = k;
        repeat_en   = r;
        reset_reset = rs;
        model(k, r, rs);
    endtask

    task automatic hold(input logic [3:0] k, input logic [3:0] r, input int n);
        repeat (n) step(k, r, 1'b0);
    endtask

    // Monitor: one scoreboard entry per clock edge.
    initial begin
        logic [15:0] exp_v, got_v;
        int          n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                got_v = {pushbuttons_export, btn_press, btn_release, btn_repeat};
                n++;
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL edge%0d outputs(export,press,release,repeat) got=%h exp=%h",
                             n, got_v, exp_v);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] lv, rv;
        int         len;
        repeat (3) step(4'hF, 4'h0, 1'b1);
        hold(4'hF, 4'h0, 5);
        hold(4'hE, 4'h0, 15);
        hold(4'hF, 4'h0, 15);
        hold(4'hD, 4'h0, 7);
        hold(4'hF, 4'h0, 15);
        hold(4'hB, 4'h4, 50);
        hold(4'hF, 4'h4, 15);
        hold(4'hB, 4'h0, 40);
        hold(4'hB, 4'h4, 10);
        hold(4'hF, 4'h4, 15);
        for (int h = 28; h <= 36; h++) begin
            hold(4'h7, 4'h8, h);
            hold(4'hF, 4'h8, 14);
        end
        hold(4'h0, 4'hF, 5);
        repeat (2) step(4'h0, 4'hF, 1'b1);
        hold(4'h0, 4'hF, 20);
        hold(4'hF, 4'hF, 15);
        for (int s = 0; s < 80; s++) begin
            lv  = 4'($urandom);
            rv  = 4'($urandom);
            len = $urandom_range(1, 45);
            if ($urandom_range(0, 19) == 0) step(lv, rv, 1'b1);
            hold(lv, rv, len);
            if ($urandom_range(0, 3) == 0) hold(lv, ~rv, $urandom_range(1, 12));
        end
        hold(4'hF, 4'h0, 15);
        @(posedge clk);
        #2;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
